mdio_master: RTL and testbench
==============================

# mdio_master

Clause-45 MDIO management-frame engine for the 10G PHY. It sits between the host MDIO access decoder and the PHY management pins. The decoder supplies a 32-bit access word and a multi-cycle `acc_en` pulse; this block serializes the word into a preamble plus frame on MDC/MDIO and returns read data. It also buffers one access that arrives while a frame is in flight, and counts any accesses it has to drop.

## Interface
- `MDC_DIV`, default 50: `clk` cycles per MDC half-period. At 250 MHz this gives 2.5 MHz. Legal range is 2..255.
- `clk`  in  1  core clock
- `rst`  in  1  reset: synchronous, active-high
- `acc_data`  in  32  access word. Fields: [31:30] ST, [29:28] OP, [27:23] PRTAD, [22:18] DEVAD, [17:16] TA (ignored; always sent as 2'b10 on writes), [15:0] address/data.
- `acc_en`  in  1  access strobe, high for ≥2 cycles. Only its rising edge is significant.
- `mdc`  out  1  management clock
- `mdio_o`  out  1  MDIO output value
- `mdio_t`  out  1  tristate enable: 1 = released (input)
- `mdio_i`  in  1  MDIO pin input, already synchronized externally
- `rd_data`  out  16  data captured by the last read-type frame
- `rd_valid`  out  1  one-cycle pulse when `rd_data` is updated
- `busy`  out  1  a frame is in flight or one is pending
- `drop_cnt`  out  16  count of dropped accesses; saturates at 0xFFFF

## Operation
- Edge detect: `acc_en_q` is registered. `acc_rise = acc_en & ~acc_en_q`, and `acc_data` is captured in the `acc_rise` cycle.
- Pending slot: a one-deep register (`pend_vld`, `pend_word`).
  - On `acc_rise` in IDLE, the word goes directly to the shifter and the slot is bypassed.
  - On `acc_rise` while a frame is active: if the slot is empty, the word is loaded into it. If the slot is full, the word is dropped and `drop_cnt` increments.
  - When the slot is freed and loaded in the same cycle, the load wins and the slot stays full with the new word.
- State machine:
  - IDLE → PRE on a start condition: a direct `acc_rise`, or `pend_vld` set.
  - PRE sends 32 bits, all 1, with the pin driven.
  - FRAME sends 32 bits, MSB first: ST, OP, PRTAD, DEVAD, TA, data.
  - GAP lasts one full MDC period with the pin released.
  - GAP → IDLE. If `pend_vld` is set, GAP goes straight to PRE instead and the slot is cleared.
- Read-type frames are OP = 2'b11 (read) and 2'b10 (post-read-increment).
  - `mdio_t` goes to 1 from FRAME bit 14 (first TA bit) through bit 31.
  - Bits 16..31 are sampled from `mdio_i` into a shift register.
- Write/address frames (OP = 2'b01 / 2'b00) drive all 32 frame bits. TA is sent as 1, 0.
- ST is transmitted as given by `acc_data[31:30]`. The block does not force 2'b00 and does no legality checking on ST or OP.

## Timing
- Reset values: `mdc` = 0, `mdio_o` = 1, `mdio_t` = 1, `rd_data` = 0, `rd_valid` = 0, `busy` = 0, `drop_cnt` = 0; slot empty; state IDLE. Reset mid-frame aborts immediately and the pin is released on the next edge.
- MDC runs only outside IDLE. IDLE holds `mdc` = 0.
- Each bit occupies 2·`MDC_DIV` cycles:
  - The bit is presented while `mdc` = 0.
  - `mdc` rises after `MDC_DIV` cycles. Read bits are sampled from `mdio_i` in that same rise cycle.
  - `mdc` falls after `MDC_DIV` more cycles, and the next bit is presented in that same falling cycle.
- Start latency: in the cycle after `acc_rise`, state = PRE, `mdio_t` = 0, `mdio_o` = 1, `busy` = 1.
- Frame length: PRE + FRAME = 64 bits = 128·`MDC_DIV` cycles. GAP adds 2·`MDC_DIV` cycles.
- `rd_valid` and the `rd_data` update happen in the cycle the FSM enters GAP, only for read-type frames.
- `busy` = 1 from the cycle after `acc_rise` until the cycle IDLE is re-entered with the slot empty.
- A back-to-back pending frame starts PRE in the cycle after GAP ends, with no IDLE cycle between frames.

## Structure
- `mdio_pkg` holds:
  - the field offset constants `ST_MSB`, `OP_MSB`, `PRTAD_MSB`, `DEVAD_MSB`;
  - the OP codes `OP_ADDR` = 00, `OP_WR` = 01, `OP_RDINC` = 10, `OP_RD` = 11;
  - the state encoding;
  - `PRE_BITS` = 32 and `FRM_BITS` = 32.
- Sub-module `mdio_clkgen`: the `MDC_DIV` divider. It takes an enable input and produces `mdc` plus one-cycle `rise`/`fall` strobes. The top level holds the FSM, 6-bit bit counter, shifters, pending slot and counter.

## Test plan
All tests use `MDC_DIV` = 2.
1. Write frame. Issue `acc_en` for 5 cycles with `acc_data` = 0x1586_ABCD. Expected:
   - 32 ones, then the frame bits 0001 0101 1000 0110 1010 1011 1100 1101 (0x1586ABCD MSB first, TA shown as 10);
   - `mdio_t` = 0 throughout the frame;
   - `busy` lasts 1 + 256 + 4 cycles;
   - no `rd_valid` pulse.
2. Read frame. Issue `acc_data` = 0x3586_0000 with the PHY model driving 0xBEEF on bits 16..31. Expected: `mdio_t` = 1 from frame bit 14; `rd_valid` pulses once; `rd_data` = 0xBEEF.
3. Back-to-back. Issue a second `acc_rise` mid-frame. Expected: it is held in the slot, and the second PRE starts in the cycle after the first GAP ends.
4. Overflow. Issue three `acc_rise` during one frame. Expected: `drop_cnt` = 1 and exactly 2 frames total. Then preload `drop_cnt` to 0xFFFF via force and drop once more: it stays 0xFFFF.
5. Reset mid-frame. Assert `rst` at bit 40. Expected in the next cycle: `mdc` = 0, `mdio_t` = 1, `busy` = 0; the slot is cleared; no `rd_valid` pulse.
6. Level hold. Hold `acc_en` high for 1000 cycles. Expected: exactly one frame.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and helpers for the Clause-45 MDIO master.
package mdio_pkg;

  localparam int ST_MSB    = 31;
  localparam int OP_MSB    = 29;
  localparam int PRTAD_MSB = 27;
  localparam int DEVAD_MSB = 22;
  localparam int TA_MSB    = 17;

  localparam logic [1:0] OP_ADDR  = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_RDINC = 2'b10;
  localparam logic [1:0] OP_RD    = 2'b11;

  localparam int PRE_BITS = 32;
  localparam int FRM_BITS = 32;

  // Frame bit positions where a read releases the pin and starts sampling.
  localparam int TA_BIT = 14;
  localparam int RD_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_FRAME,
    ST_GAP
  } state_e;

  function automatic logic is_read(input logic [1:0] op);
    return op[1];
  endfunction

  // Turnaround is always transmitted as 1,0 regardless of the access word.
  function automatic logic [31:0] frame_word(input logic [31:0] w);
    logic [31:0] f;
    f = w;
    f[TA_MSB -: 2] = 2'b10;
    return f;
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC divider: MDC_DIV clk cycles per half-period, held low while disabled.
module mdio_clkgen #(
  parameter int MDC_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt_q, cnt_d;
  logic       mdc_q, mdc_d;

  // Strobes are high in the cycle before mdc changes, so state updated on
  // the same edge lines up with the mdc transition.
  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    rise  = 1'b0;
    fall  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (cnt_q == 8'(MDC_DIV - 1)) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
      rise  = ~mdc_q;
      fall  = mdc_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc = mdc_q;

endmodule

// File: rtl/mdio_master.sv
// Clause-45 MDIO frame engine: preamble + 32-bit frame, read capture,
// one-deep pending slot and a saturating drop counter.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int MDC_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] acc_data,
  input  logic        acc_en,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  state_e      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic        rd_op_q, rd_op_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_word_q, pend_word_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        acc_en_q;

  logic        acc_rise, load_pre, mdc_rise, mdc_fall;
  logic [31:0] start_word;
  logic [4:0]  frm_idx;

  mdio_clkgen #(.MDC_DIV(MDC_DIV)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .mdc  (mdc),
    .rise (mdc_rise),
    .fall (mdc_fall)
  );

  // bit_q runs 0..63 over preamble then frame; low bits index the frame.
  assign frm_idx    = bit_q[4:0];
  assign acc_rise   = acc_en & ~acc_en_q;
  assign start_word = pend_vld_q ? pend_word_q : acc_data;

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rd_op_d     = rd_op_q;
    rx_d        = rx_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_word_d = pend_word_q;
    drop_cnt_d  = drop_cnt_q;
    load_pre    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_vld_q || acc_rise) load_pre = 1'b1;
      end
      ST_PRE: begin
        if (mdc_fall) begin
          bit_d = bit_q + 6'd1;
          if (bit_q == 6'(PRE_BITS - 1)) state_d = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (mdc_rise && rd_op_q && frm_idx >= 5'(RD_BIT)) rx_d = {rx_q[14:0], mdio_i};
        if (mdc_fall) begin
          bit_d = bit_q + 6'd1;
          tx_d  = {tx_q[30:0], 1'b0};
          if (bit_q == 6'(PRE_BITS + FRM_BITS - 1)) begin
            state_d = ST_GAP;
            if (rd_op_q) begin
              rd_data_d  = rx_q;
              rd_valid_d = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (mdc_fall) begin
          if (pend_vld_q) load_pre = 1'b1;
          else            state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_pre) begin
      state_d = ST_PRE;
      bit_d   = '0;
      tx_d    = frame_word(start_word);
      rd_op_d = is_read(start_word[OP_MSB -: 2]);
      if (pend_vld_q) pend_vld_d = 1'b0;
    end

    // Only an idle engine with an empty slot takes the word directly.
    if (acc_rise && !(state_q == ST_IDLE && !pend_vld_q)) begin
      if (!pend_vld_q || (load_pre && pend_vld_q)) begin
        pend_vld_d  = 1'b1;
        pend_word_d = acc_data;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    busy_d = (state_q != ST_IDLE) | load_pre | pend_vld_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      tx_q        <= '0;
      rd_op_q     <= 1'b0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_word_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rd_op_q     <= rd_op_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      pend_vld_q  <= pend_vld_d;
      pend_word_q <= pend_word_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Not reset, so a strobe held high across reset does not look like a new edge.
  always_ff @(posedge clk) begin
    acc_en_q <= acc_en;
  end

  assign mdio_o   = (state_q == ST_FRAME) ? tx_q[31] : 1'b1;
  assign mdio_t   = (state_q == ST_IDLE) || (state_q == ST_GAP) ||
                    (state_q == ST_FRAME && rd_op_q && frm_idx >= 5'(TA_BIT));
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: bit-level frame model, PHY read model,
// table-driven frames plus back-to-back, overflow, reset and level-hold cases.
module tb_mdio_master;

  localparam int DIV       = 2;
  localparam int RISES_FR  = 65;               // 64 frame bits + one gap period
  localparam int FRAME_CYC = 2 * DIV * RISES_FR;
  localparam int BUSY_ONE  = FRAME_CYC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] acc_data;
  logic        acc_en;
  logic        mdc, mdio_o, mdio_t;
  logic        mdio_i = 1'b1;
  logic [15:0] rd_data;
  logic        rd_valid, busy;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  mdio_master #(.MDC_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .acc_data (acc_data),
    .acc_en   (acc_en),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .mdio_i   (mdio_i),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Pin monitor and PHY model, all sampled on the falling clk edge.
  int          cyc = 0, rise_cnt = 0, busy_cyc = 0, rv_cnt = 0;
  logic [15:0] rv_data = '0;
  logic [15:0] phy_val = '0;
  logic        mdc_prev = 1'b0;
  logic        rec_o [0:399];
  logic        rec_t [0:399];
  int          rec_time [0:399];

  function automatic logic phy_bit(input int pos, input logic [15:0] val);
    int idx;
    if (pos >= 48 && pos <= 63) begin
      idx = 63 - pos;
      return val[idx];
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (mdc && !mdc_prev) begin
      if (rise_cnt < 400) begin
        rec_o[rise_cnt]    = mdio_o;
        rec_t[rise_cnt]    = mdio_t;
        rec_time[rise_cnt] = cyc;
      end
      rise_cnt++;
    end
    mdc_prev = mdc;
    if (busy === 1'b1) busy_cyc++;
    if (rd_valid === 1'b1) begin
      rv_cnt++;
      rv_data = rd_data;
    end
    mdio_i = phy_bit(rise_cnt % RISES_FR, phy_val);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: 32 preamble ones, then the word with TA replaced by 1,0.
  function automatic logic [63:0] exp_o(input logic [31:0] w);
    logic [31:0] f;
    f = w;
    f[17:16] = 2'b10;
    return {32'hFFFF_FFFF, f};
  endfunction

  // Read-type ops release the pin from frame bit 14 (stream bit 46) to the end.
  function automatic logic [63:0] exp_t(input logic [31:0] w);
    return w[29] ? 64'h0000_0000_0003_FFFF : 64'h0;
  endfunction

  task automatic chk_frame(input int f, input logic [31:0] w, input string tag);
    logic [63:0] go, gt, eo, et;
    for (int k = 0; k < 64; k++) begin
      go[63-k] = rec_o[f*RISES_FR + k];
      gt[63-k] = rec_t[f*RISES_FR + k];
    end
    eo = exp_o(w);
    et = exp_t(w);
    chk({tag, "_bits"}, go & ~et, eo & ~et);
    chk({tag, "_tris"}, gt, et);
    chk({tag, "_gap_rel"}, 64'(rec_t[f*RISES_FR + 64]), 64'd1);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    cyc      = 0;
    rise_cnt = 0;
    busy_cyc = 0;
    rv_cnt   = 0;
  endtask

  task automatic issue(input logic [31:0] w, input int hold, input bit check_lat);
    @(negedge clk);
    acc_en   = 1'b1;
    acc_data = w;
    @(negedge clk);
    if (check_lat) begin
      chk("lat_busy", 64'(busy), 64'd1);
      chk("lat_mdio_t", 64'(mdio_t), 64'd0);
      chk("lat_mdio_o", 64'(mdio_o), 64'd1);
    end
    repeat (hold - 1) @(negedge clk);
    acc_en   = 1'b0;
    acc_data = $urandom;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [15:0] phy;
    logic        exp_rv;
    logic [15:0] exp_rd;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  initial begin
    logic [15:0] last_rd;
    logic [31:0] w1, w2, w3;

    rst      = 1'b1;
    acc_en   = 1'b0;
    acc_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_mdio_o", 64'(mdio_o), 64'd1);
    chk("rst_mdio_t", 64'(mdio_t), 64'd1);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Directed entries first, random words after; expected read data follows
    // the rule that only OP[1]=1 frames update rd_data.
    vecs[0] = '{32'h1586_ABCD, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{32'h3586_0000, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[2] = '{32'h2A5F_1234, 16'h1357, 1'b1, 16'h1357};
    vecs[3] = '{32'h0ABC_5555, 16'hFFFF, 1'b0, 16'h1357};
    last_rd = 16'h1357;
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].word   = $urandom;
      vecs[i].phy    = 16'($urandom);
      vecs[i].exp_rv = vecs[i].word[29];
      vecs[i].exp_rd = vecs[i].exp_rv ? vecs[i].phy : last_rd;
      last_rd        = vecs[i].exp_rd;
    end

    for (int i = 0; i < NVEC; i++) begin
      phy_val = vecs[i].phy;
      clear_mon();
      issue(vecs[i].word, 5, 1'b1);
      wait_idle(600, "vec");
      chk("vec_rises", 64'(rise_cnt), 64'(RISES_FR));
      chk_frame(0, vecs[i].word, "vec");
      chk("vec_busy_cycles", 64'(busy_cyc), 64'(BUSY_ONE));
      chk("vec_rd_valid_cnt", 64'(rv_cnt), 64'(vecs[i].exp_rv));
      chk("vec_rd_data", 64'(rd_data), 64'(vecs[i].exp_rd));
      if (vecs[i].exp_rv) chk("vec_rd_pulse_data", 64'(rv_data), 64'(vecs[i].exp_rd));
      $display("vec %0d word=%08h rd_data=%04h rd_valid_pulses=%0d busy_cycles=%0d",
               i, vecs[i].word, rd_data, rv_cnt, busy_cyc);
    end

    // Back-to-back: second access lands mid-frame and follows without an idle cycle.
    w1 = 32'h3123_0000;
    w2 = 32'h1499_7777;
    phy_val = 16'hA5C3;
    clear_mon();
    issue(w1, 5, 1'b1);
    repeat (100) @(negedge clk);
    issue(w2, 5, 1'b0);
    wait_idle(1200, "b2b");
    chk("b2b_rises", 64'(rise_cnt), 64'(2 * RISES_FR));
    chk_frame(0, w1, "b2b_f0");
    chk_frame(1, w2, "b2b_f1");
    chk("b2b_frame_spacing", 64'(rec_time[RISES_FR] - rec_time[0]), 64'(FRAME_CYC));
    chk("b2b_busy_cycles", 64'(busy_cyc), 64'(2 * FRAME_CYC + 1));
    chk("b2b_rd_data", 64'(rd_data), 64'(16'hA5C3));
    $display("b2b rises=%0d spacing=%0d busy_cycles=%0d rd_data=%04h",
             rise_cnt, rec_time[RISES_FR] - rec_time[0], busy_cyc, rd_data);

    // Overflow: start + held + dropped.
    w1 = 32'h1111_2222;
    w2 = 32'h1333_4444;
    w3 = 32'h1555_6666;
    clear_mon();
    issue(w1, 3, 1'b0);
    issue(w2, 3, 1'b0);
    issue(w3, 3, 1'b0);
    wait_idle(1200, "ovf");
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_rises", 64'(rise_cnt), 64'(2 * RISES_FR));
    chk_frame(1, w2, "ovf_f1");
    $display("ovf drop_cnt=%04h frames=%0d", drop_cnt, rise_cnt / RISES_FR);

    @(negedge clk);
    force dut.drop_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.drop_cnt_q;
    clear_mon();
    issue(w1, 3, 1'b0);
    issue(w2, 3, 1'b0);
    issue(w3, 3, 1'b0);
    wait_idle(1200, "sat");
    chk("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
    chk("sat_rises", 64'(rise_cnt), 64'(2 * RISES_FR));
    $display("sat drop_cnt=%04h frames=%0d", drop_cnt, rise_cnt / RISES_FR);

    // Reset mid-frame, with a second access waiting in the slot.
    phy_val = 16'h1234;
    clear_mon();
    issue(32'h3000_0000, 3, 1'b0);
    issue(32'h1777_8888, 3, 1'b0);
    begin
      int n;
      n = 0;
      while (rise_cnt < 40 && n < 600) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (rise_cnt < 40) begin
        failures++;
        $display("FAIL rstmid_reach_bit40: rises=%0d required 40", rise_cnt);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_mdc", 64'(mdc), 64'd0);
    chk("rstmid_mdio_t", 64'(mdio_t), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_rd_valid_cnt", 64'(rv_cnt), 64'd0);
    rst = 1'b0;
    clear_mon();
    repeat (300) @(negedge clk);
    chk("rstmid_slot_cleared", 64'(busy_cyc), 64'd0);
    chk("rstmid_no_mdc", 64'(rise_cnt), 64'd0);
    chk("rstmid_drop_cnt", 64'(drop_cnt), 64'd0);
    $display("rstmid busy_after=%0d rises_after=%0d", busy_cyc, rise_cnt);

    // Level hold: one edge, one frame.
    clear_mon();
    @(negedge clk);
    acc_en   = 1'b1;
    acc_data = 32'h1586_ABCD;
    repeat (1000) @(negedge clk);
    acc_en = 1'b0;
    wait_idle(600, "hold");
    chk("hold_rises", 64'(rise_cnt), 64'(RISES_FR));
    chk("hold_busy_cycles", 64'(busy_cyc), 64'(BUSY_ONE));
    $display("hold frames=%0d busy_cycles=%0d", rise_cnt / RISES_FR, busy_cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
